// File: rtl/eth_frame_depacketizer.sv
// Rebuilds camera frames from the Ethernet RX byte stream: sync hunt, 4-byte
// dimension header, then RGB565 pixels on a valid/ready stream with SOF/EOF.
module eth_frame_depacketizer #(
    parameter logic [31:0] SYNC_WORD = 32'hA55A_A55A,
    parameter logic [15:0] MAX_W     = 16'd640,
    parameter logic [15:0] MAX_H     = 16'd480
) (
    input  logic        CLK_50M,
    input  logic        reset_n,
    output logic        Eth_fifo_rden,
    input  logic [7:0]  Eth_fifo_rddata,
    input  logic        Eth_fifo_rdempty,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eof,
    output logic [15:0] frame_width,
    output logic [15:0] frame_height,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_HDR    = 3'd1,
        ST_CHECK  = 3'd2,
        ST_PIX_HI = 3'd3,
        ST_PIX_LO = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  skid0_r, skid1_r;
    logic [1:0]  skid_cnt_r;
    logic        inflight_r;
    logic        rd_enable_r;
    logic [31:0] sr_r;
    logic [1:0]  hdr_idx_r;
    logic [15:0] hdr_w_r, hdr_h_r;
    logic [15:0] x_r, y_r;
    logic        first_r;
    logic [7:0]  hi_r;
    logic [15:0] pix_data_r, frame_width_r, frame_height_r, frame_cnt_r, err_cnt_r;
    logic        pix_valid_r, pix_sof_r, pix_eof_r, busy_r;

    logic        pop_s, rden_s;
    logic [1:0]  level_s;
    logic [31:0] shifted_s;
    logic        pix_last_s, hdr_bad_s;

    // Parser byte consumption; PIX_LO only pops when the output register can take the pixel.
    always_comb begin
        pop_s = 1'b0;
        if (skid_cnt_r != 2'd0) begin
            case (state_r)
                ST_HUNT, ST_HDR, ST_PIX_HI: pop_s = 1'b1;
                ST_PIX_LO:                  pop_s = !pix_valid_r || pix_ready;
                default:                    pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Read request: occupancy counts this cycle's pop so a full-rate stream keeps one read in flight.
    always_comb begin
        level_s   = skid_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
        rden_s    = rd_enable_r && !Eth_fifo_rdempty && (level_s < 2'd2);
        shifted_s = {sr_r[23:0], skid0_r};
        pix_last_s = (x_r == frame_width_r - 16'd1) && (y_r == frame_height_r - 16'd1);
        hdr_bad_s  = (hdr_w_r == 16'd0) || (hdr_h_r == 16'd0) ||
                     (hdr_w_r > MAX_W) || (hdr_h_r > MAX_H);
    end

    // Two-entry byte skid buffer fed by the normal-mode FIFO read port.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            skid0_r     <= 8'd0;
            skid1_r     <= 8'd0;
            skid_cnt_r  <= 2'd0;
            inflight_r  <= 1'b0;
            rd_enable_r <= 1'b0;
        end else begin
            rd_enable_r <= 1'b1;
            inflight_r  <= rden_s;
            skid_cnt_r  <= skid_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
            if (pop_s) begin
                skid0_r <= skid1_r;
            end
            if (inflight_r) begin
                if ((skid_cnt_r - {1'b0, pop_s}) == 2'd0) begin
                    skid0_r <= Eth_fifo_rddata;
                end else begin
                    skid1_r <= Eth_fifo_rddata;
                end
            end
        end
    end

    // Parser FSM with the registered pixel output stage.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_HUNT;
            sr_r           <= 32'd0;
            hdr_idx_r      <= 2'd0;
            hdr_w_r        <= 16'd0;
            hdr_h_r        <= 16'd0;
            x_r            <= 16'd0;
            y_r            <= 16'd0;
            first_r        <= 1'b0;
            hi_r           <= 8'd0;
            pix_data_r     <= 16'd0;
            pix_valid_r    <= 1'b0;
            pix_sof_r      <= 1'b0;
            pix_eof_r      <= 1'b0;
            frame_width_r  <= 16'd0;
            frame_height_r <= 16'd0;
            frame_cnt_r    <= 16'd0;
            err_cnt_r      <= 16'd0;
            busy_r         <= 1'b0;
        end else begin
            if (pix_valid_r && pix_ready) begin
                pix_valid_r <= 1'b0;
                pix_sof_r   <= 1'b0;
                pix_eof_r   <= 1'b0;
            end
            case (state_r)
                ST_HUNT: begin
                    if (pop_s) begin
                        if (shifted_s == SYNC_WORD) begin
                            sr_r      <= 32'd0;
                            hdr_idx_r <= 2'd0;
                            state_r   <= ST_HDR;
                            busy_r    <= 1'b1;
                        end else begin
                            sr_r <= shifted_s;
                        end
                    end
                end
                ST_HDR: begin
                    if (pop_s) begin
                        case (hdr_idx_r)
                            2'd0:    hdr_w_r[15:8] <= skid0_r;
                            2'd1:    hdr_w_r[7:0]  <= skid0_r;
                            2'd2:    hdr_h_r[15:8] <= skid0_r;
                            default: hdr_h_r[7:0]  <= skid0_r;
                        endcase
                        hdr_idx_r <= hdr_idx_r + 2'd1;
                        if (hdr_idx_r == 2'd3) begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (hdr_bad_s) begin
                        if (err_cnt_r != 16'hFFFF) begin
                            err_cnt_r <= err_cnt_r + 16'd1;
                        end
                        sr_r    <= 32'd0;
                        state_r <= ST_HUNT;
                        busy_r  <= 1'b0;
                    end else begin
                        frame_width_r  <= hdr_w_r;
                        frame_height_r <= hdr_h_r;
                        x_r            <= 16'd0;
                        y_r            <= 16'd0;
                        first_r        <= 1'b1;
                        state_r        <= ST_PIX_HI;
                    end
                end
                ST_PIX_HI: begin
                    if (pop_s) begin
                        hi_r    <= skid0_r;
                        state_r <= ST_PIX_LO;
                    end
                end
                ST_PIX_LO: begin
                    if (pop_s) begin
                        pix_data_r  <= {hi_r, skid0_r};
                        pix_valid_r <= 1'b1;
                        pix_sof_r   <= first_r;
                        pix_eof_r   <= pix_last_s;
                        first_r     <= 1'b0;
                        if (x_r == frame_width_r - 16'd1) begin
                            x_r <= 16'd0;
                            y_r <= y_r + 16'd1;
                        end else begin
                            x_r <= x_r + 16'd1;
                        end
                        if (pix_last_s) begin
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                            state_r     <= ST_HUNT;
                            busy_r      <= 1'b0;
                        end else begin
                            state_r <= ST_PIX_HI;
                        end
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Eth_fifo_rden = rden_s;
    assign pix_data      = pix_data_r;
    assign pix_valid     = pix_valid_r;
    assign pix_sof       = pix_sof_r;
    assign pix_eof       = pix_eof_r;
    assign frame_width   = frame_width_r;
    assign frame_height  = frame_height_r;
    assign frame_cnt     = frame_cnt_r;
    assign err_cnt       = err_cnt_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_eth_frame_depacketizer.sv
// Directed bench for eth_frame_depacketizer: byte-queue FIFO model feeds the
// DUT, expected pixels go to a scoreboard and are compared on acceptance.
module tb_eth_frame_depacketizer;

    logic        CLK_50M = 1'b0;
    logic        reset_n = 1'b0;
    logic        Eth_fifo_rden;
    logic [7:0]  Eth_fifo_rddata = 8'd0;
    logic        Eth_fifo_rdempty = 1'b1;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof, pix_eof;
    logic [15:0] frame_width, frame_height, frame_cnt, err_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int got_cnt = 0;
    int rden_viol = 0;
    int occ_viol = 0;
    logic [7:0]  fifo_q[$];
    logic [17:0] exp_q[$];
    logic        gap_en = 1'b0;
    logic        gap_ph = 1'b0;
    logic        held_v = 1'b0;
    logic [18:0] held_d = 19'd0;

    eth_frame_depacketizer dut (
        .CLK_50M          (CLK_50M),
        .reset_n          (reset_n),
        .Eth_fifo_rden    (Eth_fifo_rden),
        .Eth_fifo_rddata  (Eth_fifo_rddata),
        .Eth_fifo_rdempty (Eth_fifo_rdempty),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_sof          (pix_sof),
        .pix_eof          (pix_eof),
        .frame_width      (frame_width),
        .frame_height     (frame_height),
        .frame_cnt        (frame_cnt),
        .err_cnt          (err_cnt),
        .busy             (busy)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: normal mode, data one cycle after rden; optional empty gap every other cycle.
    always @(posedge CLK_50M) begin
        gap_ph <= ~gap_ph;
        if (Eth_fifo_rden && fifo_q.size() != 0) begin
            Eth_fifo_rddata <= fifo_q.pop_front();
        end
        Eth_fifo_rdempty <= (fifo_q.size() == 0) || (gap_en && !gap_ph);
    end

    // Monitor: stall stability, scoreboard compare on handshake, interface sanity.
    always @(negedge CLK_50M) begin
        if (!reset_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_hold", {13'd0, pix_valid, pix_data, pix_sof, pix_eof}, {13'd0, held_d});
            end
            held_v = pix_valid && !pix_ready;
            held_d = {1'b1, pix_data, pix_sof, pix_eof};
            if (pix_valid && pix_ready) begin
                got_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", {14'd0, pix_data, pix_sof, pix_eof}, 32'hFFFF_FFFF);
                end else begin
                    chk("pixel", {14'd0, pix_data, pix_sof, pix_eof}, {14'd0, exp_q.pop_front()});
                end
            end
            if (Eth_fifo_rden && Eth_fifo_rdempty) rden_viol++;
            if (dut.skid_cnt_r > 2'd2) occ_viol++;
        end
    end

    task automatic push_hdr(input logic [15:0] w, input logic [15:0] h);
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
        fifo_q.push_back(w[15:8]); fifo_q.push_back(w[7:0]);
        fifo_q.push_back(h[15:8]); fifo_q.push_back(h[7:0]);
    endtask

    task automatic push_pix(input logic [7:0] hi, input logic [7:0] lo,
                            input logic sof, input logic eof, input logic expect_it);
        fifo_q.push_back(hi);
        fifo_q.push_back(lo);
        if (expect_it) exp_q.push_back({hi, lo, sof, eof});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy || pix_valid) && n < 2000) begin
            @(posedge CLK_50M); #1;
            n++;
        end
        chk(tag, {31'd0, n < 2000}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #5;
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_data", {16'd0, pix_data}, 32'd0);
        chk("rst_sofeof", {30'd0, pix_sof, pix_eof}, 32'd0);
        chk("rst_cnts", {frame_cnt, err_cnt}, 32'd0);
        chk("rst_dims", {frame_width, frame_height}, 32'd0);
        chk("rst_busy_rden", {30'd0, busy, Eth_fifo_rden}, 32'd0);
        repeat (3) @(posedge CLK_50M);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge CLK_50M);
        #1;

        // 1: 2x2 frame at full rate
        push_hdr(16'd2, 16'd2);
        push_pix(8'h11, 8'h22, 1'b1, 1'b0, 1'b1);
        push_pix(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
        push_pix(8'h55, 8'h66, 1'b0, 1'b0, 1'b1);
        push_pix(8'h77, 8'h88, 1'b0, 1'b1, 1'b1);
        wait_idle("t1_drain");
        chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t1_dims", {frame_width, frame_height}, {16'd2, 16'd2});
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: misaligned garbage then a 1x1 frame
        fifo_q.push_back(8'h00); fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h5A); fifo_q.push_back(8'hA5);
        push_hdr(16'd1, 16'd1);
        push_pix(8'hAB, 8'hCD, 1'b1, 1'b1, 1'b1);
        wait_idle("t2_drain");
        chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        chk("t2_dims", {frame_width, frame_height}, {16'd1, 16'd1});

        // 3: width 641 rejected, then a valid 1x1 frame
        push_hdr(16'h0281, 16'd1);
        push_hdr(16'd1, 16'd1);
        push_pix(8'h12, 8'h34, 1'b1, 1'b1, 1'b1);
        wait_idle("t3_drain");
        chk("t3_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd3);

        // 4: 4x1 frame with pix_ready pattern 1,0,0,1
        push_hdr(16'd4, 16'd1);
        push_pix(8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
        push_pix(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        push_pix(8'h05, 8'h06, 1'b0, 1'b0, 1'b1);
        push_pix(8'h07, 8'h08, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK_50M); #1;
            pix_ready = ((i % 4) == 0) || ((i % 4) == 3);
        end
        @(posedge CLK_50M); #1;
        pix_ready = 1'b1;
        wait_idle("t4_drain");
        chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd4);
        chk("t4_dims", {frame_width, frame_height}, {16'd4, 16'd1});

        // 5: FIFO empty between bytes, 2x1 frame
        gap_en = 1'b1;
        push_hdr(16'd2, 16'd1);
        push_pix(8'h9A, 8'hBC, 1'b1, 1'b0, 1'b1);
        push_pix(8'hDE, 8'hF0, 1'b0, 1'b1, 1'b1);
        wait_idle("t5_drain");
        gap_en = 1'b0;
        chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd5);

        // 6: reset after the first pixel of a 2x2 frame
        begin
            int g0;
            int n;
            g0 = got_cnt;
            n = 0;
            push_hdr(16'd2, 16'd2);
            push_pix(8'hE1, 8'hE2, 1'b1, 1'b0, 1'b1);
            push_pix(8'hE3, 8'hE4, 1'b0, 1'b0, 1'b0);
            push_pix(8'hE5, 8'hE6, 1'b0, 1'b0, 1'b0);
            push_pix(8'hE7, 8'hE8, 1'b0, 1'b1, 1'b0);
            while (got_cnt == g0 && n < 500) begin
                @(posedge CLK_50M);
                n++;
            end
            chk("t6_first_pixel_seen", {31'd0, n < 500}, 32'd1);
        end
        #1 reset_n = 1'b0;
        #2;
        chk("t6_rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("t6_rst_data", {16'd0, pix_data}, 32'd0);
        chk("t6_rst_sofeof", {30'd0, pix_sof, pix_eof}, 32'd0);
        chk("t6_rst_cnts", {frame_cnt, err_cnt}, 32'd0);
        chk("t6_rst_dims", {frame_width, frame_height}, 32'd0);
        chk("t6_rst_busy_rden", {30'd0, busy, Eth_fifo_rden}, 32'd0);
        chk("t6_sb_empty", exp_q.size(), 32'd0);
        fifo_q.delete();
        repeat (2) @(posedge CLK_50M);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge CLK_50M);
        #1;
        push_hdr(16'd1, 16'd1);
        push_pix(8'hC3, 8'hD4, 1'b1, 1'b1, 1'b1);
        wait_idle("t6_drain");
        chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t6_dims", {frame_width, frame_height}, {16'd1, 16'd1});

        // Interface sanity accumulated over the run
        chk("rden_while_empty", rden_viol, 32'd0);
        chk("skid_occupancy", occ_viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
